// File: rtl/adc_sample_sched.sv
// APB-programmed ADC sampling scheduler: issues conversion requests, averages
// 2^AVG samples per group and publishes each result to a register and a stream.
module adc_sample_sched #(
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [11:0]         PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [11:0]         adc_data,
  output logic                res_valid,
  output logic [11:0]         res_data,
  input  logic                res_ready,
  output logic                irq
);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE, WAIT} state_t;

  state_t              state_q, state_d;
  logic                en_q, cont_q, irq_en_q;
  logic [PERIOD_W-1:0] period_q, per_l_q, per_l_d, wcnt_q, wcnt_d;
  logic [1:0]          avg_q, avg_l_q, avg_l_d;
  logic                rdy_q, ovr_q, to_q;
  logic [11:0]         result_q, avg_res;
  logic                res_valid_q;
  logic [11:0]         res_data_q;
  logic [14:0]         acc_q, acc_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                adc_start_q, adc_start_d;
  logic                push, to_set, grp_start, conv_entry;

  logic wr, rd, wr_ctrl, wr_status, rd_result, en_nxt, cont_nxt, start_stb;
  assign wr        = PSEL & PENABLE & PWRITE;
  assign rd        = PSEL & PENABLE & ~PWRITE;
  assign wr_ctrl   = wr && (PADDR == 12'h000);
  assign wr_status = wr && (PADDR == 12'h00C);
  assign rd_result = rd && (PADDR == 12'h010);
  // A CTRL write can launch a group on the same edge it lands.
  assign en_nxt    = wr_ctrl ? PWDATA[0] : en_q;
  assign cont_nxt  = wr_ctrl ? PWDATA[1] : cont_q;
  assign start_stb = wr_ctrl & PWDATA[2];

  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign adc_start = adc_start_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign irq       = irq_en_q & (rdy_q | ovr_q | to_q);

  always_comb begin
    case (avg_l_q)
      2'd0:    avg_res = acc_q[11:0];
      2'd1:    avg_res = acc_q[12:1];
      2'd2:    avg_res = acc_q[13:2];
      default: avg_res = acc_q[14:3];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_l_d     = avg_l_q;
    tmr_d       = tmr_q;
    wcnt_d      = wcnt_q;
    per_l_d     = per_l_q;
    adc_start_d = 1'b0;
    push        = 1'b0;
    to_set      = 1'b0;
    grp_start   = 1'b0;
    conv_entry  = 1'b0;
    case (state_q)
      IDLE: if (en_nxt & (cont_nxt | start_stb)) grp_start = 1'b1;
      CONV: begin
        if (!en_q) state_d = IDLE;
        else if (!adc_start_q && adc_done) begin
          acc_d = acc_q + 15'(adc_data);
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == (4'd1 << avg_l_q)) state_d = DONE;
          else conv_entry = 1'b1;
        end else if (tmr_q == TMR_LAST) begin
          to_set  = 1'b1;
          state_d = IDLE;
        end else tmr_d = tmr_q + 1'b1;
      end
      DONE: begin
        push = 1'b1;
        if (en_q & cont_q) begin
          state_d = WAIT;
          wcnt_d  = '0;
          per_l_d = (period_q == '0) ? PERIOD_W'(1) : period_q;
        end else state_d = IDLE;
      end
      default: begin
        // Counts 0..P, so the launch edge lands P+2 edges after the last sample.
        if (!en_q) state_d = IDLE;
        else if (wcnt_q == per_l_q) grp_start = 1'b1;
        else wcnt_d = wcnt_q + 1'b1;
      end
    endcase
    if (grp_start) begin
      acc_d      = '0;
      cnt_d      = '0;
      avg_l_d    = avg_q;
      conv_entry = 1'b1;
    end
    if (conv_entry) begin
      state_d     = CONV;
      tmr_d       = '0;
      adc_start_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_l_q     <= '0;
      tmr_q       <= '0;
      wcnt_q      <= '0;
      per_l_q     <= '0;
      adc_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_l_q     <= avg_l_d;
      tmr_q       <= tmr_d;
      wcnt_q      <= wcnt_d;
      per_l_q     <= per_l_d;
      adc_start_q <= adc_start_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q     <= 1'b0;
      cont_q   <= 1'b0;
      irq_en_q <= 1'b0;
      period_q <= '0;
      avg_q    <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q     <= PWDATA[0];
        cont_q   <= PWDATA[1];
        irq_en_q <= PWDATA[3];
      end
      if (wr && PADDR == 12'h004) period_q <= PWDATA[PERIOD_W-1:0];
      if (wr && PADDR == 12'h008) avg_q <= PWDATA[1:0];
    end
  end

  // Status and stream; a set event always wins over a clear in the same cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rdy_q       <= 1'b0;
      ovr_q       <= 1'b0;
      to_q        <= 1'b0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      if (push) rdy_q <= 1'b1;
      else if (rd_result) rdy_q <= 1'b0;
      if (push & res_valid_q & ~res_ready) ovr_q <= 1'b1;
      else if (wr_status & PWDATA[2]) ovr_q <= 1'b0;
      if (to_set) to_q <= 1'b1;
      else if (wr_status & PWDATA[3]) to_q <= 1'b0;
      if (push) begin
        result_q    <= avg_res;
        res_data_q  <= avg_res;
        res_valid_q <= 1'b1;
      end else if (res_ready) res_valid_q <= 1'b0;
    end
  end

  always_comb begin
    PRDATA = '0;
    case (PADDR)
      12'h000: PRDATA[3:0] = {irq_en_q, 1'b0, cont_q, en_q};
      12'h004: PRDATA[PERIOD_W-1:0] = period_q;
      12'h008: PRDATA[1:0] = avg_q;
      12'h00C: PRDATA[3:0] = {to_q, ovr_q, rdy_q, state_q != IDLE};
      12'h010: PRDATA[11:0] = result_q;
      default: PRDATA = '0;
    endcase
  end

  logic unused_pwdata;
  assign unused_pwdata = ^PWDATA;
endmodule
